// File: rtl/width_gearbox.sv
// -----------------------------------------------------------------------------
// width_gearbox
//
// Single-clock data-width converter with valid/ready handshakes on both sides
// and a first-word-fall-through output FIFO.
//   * OUT_WIDTH > IN_WIDTH : packs R narrow beats into one wide word (upsize).
//   * IN_WIDTH > OUT_WIDTH : splits each wide word into R narrow beats (downsize).
//   * equal widths         : straight pass-through into the FIFO.
// R = max(IN_WIDTH,OUT_WIDTH) / min(IN_WIDTH,OUT_WIDTH).
//
// Optional feature macro: WIDTH_GEARBOX_LAST_EN
//   defined   : in_last closes a partial upsize word, out_last / out_lanes
//               travel through the FIFO with each word.
//   undefined : in_last is ignored, out_last is 0, out_lanes is R (upsize) or
//               1 (otherwise), and the FIFO stores data only.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous, active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid & in_ready
//   in_data    in   [IN_WIDTH-1:0] input beat
//   in_last    in   last beat of frame
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head
//   out_data   out  [OUT_WIDTH-1:0] FIFO head data
//   out_last   out  head word ends a frame
//   out_lanes  out  [LW-1:0] valid IN_WIDTH lanes in out_data (upsize), else 1
//   fifo_level out  [CW-1:0] current FIFO occupancy
// -----------------------------------------------------------------------------
module width_gearbox #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int MAX_W = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH,
  localparam int MIN_W = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH,
  localparam int R     = MAX_W / MIN_W,
  localparam int LW    = $clog2(R + 1),
  localparam int CW    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [LW-1:0]        out_lanes,
  output logic [CW-1:0]        fifo_level
);

  localparam int LCW = (R > 1) ? $clog2(R) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef WIDTH_GEARBOX_LAST_EN
  // FIFO entry layout: {last, lanes, data}
  localparam int EW  = OUT_WIDTH + LW + 1;
`else
  localparam int EW  = OUT_WIDTH;
`endif

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if ((MAX_W % MIN_W) != 0) begin : g_ratio_chk
    $error("width_gearbox: IN_WIDTH and OUT_WIDTH must be integer multiples");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("width_gearbox: FIFO_DEPTH must be a power of 2 and >= 2");
  end

`ifndef WIDTH_GEARBOX_LAST_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  // ---------------------------------------------------------------------------
  // Shared signals between the converter core and the FIFO
  // ---------------------------------------------------------------------------
  logic          run_q;       // low during reset, high from the first edge after
  logic          core_ready;  // converter-specific ready, before reset gating
  logic          accept;
  logic          push;
  logic [EW-1:0] push_entry;
  logic          pop;
  logic          full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // in_ready is built only from registered state (run_q, FIFO count, hold
  // state), never from in_valid/in_last or the same-cycle pop.
  assign in_ready = run_q & core_ready;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Converter core
  // ---------------------------------------------------------------------------
  if (OUT_WIDTH > IN_WIDTH) begin : g_up
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] word;
    logic [LCW-1:0]       lcnt_q, lcnt_d;
    logic                 close;

    assign core_ready = ~full;

    // Current beat merged into its lane; lanes above lcnt are still zero
    // because the accumulator is cleared whenever a word is pushed.
    // NOTE: always_comb uses blocking '=' so later statements see earlier ones;
    // always_ff uses '<=' so all registers update together at the edge.
    always_comb begin
      word = acc_q;
      word[int'(lcnt_q)*IN_WIDTH +: IN_WIDTH] = in_data;
    end

`ifdef WIDTH_GEARBOX_LAST_EN
    assign close = (lcnt_q == LCW'(R - 1)) | in_last;
`else
    assign close = (lcnt_q == LCW'(R - 1));
`endif

    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
      acc_d  = acc_q;
      lcnt_d = lcnt_q;
      if (accept) begin
        if (close) begin
          acc_d  = '0;
          lcnt_d = '0;
        end else begin
          acc_d  = word;
          lcnt_d = lcnt_q + LCW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        acc_q  <= '0;
        lcnt_q <= '0;
      end else begin
        acc_q  <= acc_d;
        lcnt_q <= lcnt_d;
      end
    end

    assign push = accept & close;
`ifdef WIDTH_GEARBOX_LAST_EN
    assign push_entry = {in_last, LW'(lcnt_q) + LW'(1), word};
`else
    assign push_entry = word;
`endif

  end else if (IN_WIDTH > OUT_WIDTH) begin : g_dn
    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic [LCW-1:0]      sidx_q, sidx_d;
    logic                last_slice;
    logic [OUT_WIDTH-1:0] slice;

    assign last_slice = (sidx_q == LCW'(R - 1));
    assign push       = hold_valid_q & ~full;
    // A new word may load on the same edge the final slice leaves the holder.
    assign core_ready = ~hold_valid_q | (last_slice & ~full);
    assign slice      = hold_q[int'(sidx_q)*OUT_WIDTH +: OUT_WIDTH];

    always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      sidx_d       = sidx_q;
      if (push) begin
        if (last_slice) begin
          hold_valid_d = 1'b0;
          sidx_d       = '0;
        end else begin
          sidx_d = sidx_q + LCW'(1);
        end
      end
      if (accept) begin
        hold_d       = in_data;
        hold_valid_d = 1'b1;
        sidx_d       = '0;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        hold_q       <= '0;
        hold_valid_q <= 1'b0;
        sidx_q       <= '0;
      end else begin
        hold_q       <= hold_d;
        hold_valid_q <= hold_valid_d;
        sidx_q       <= sidx_d;
      end
    end

`ifdef WIDTH_GEARBOX_LAST_EN
    logic hold_last_q;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     hold_last_q <= 1'b0;
      else if (accept) hold_last_q <= in_last;
    end
    assign push_entry = {hold_last_q & last_slice, LW'(1), slice};
`else
    assign push_entry = slice;
`endif

  end else begin : g_eq
    assign core_ready = ~full;
    assign push       = accept;
`ifdef WIDTH_GEARBOX_LAST_EN
    assign push_entry = {in_last, LW'(1), in_data};
`else
    assign push_entry = in_data;
`endif
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [EW-1:0] head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  assign head  = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; stale entries are never visible
  // because every head-derived output is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid  = (count_q != '0);
  assign fifo_level = count_q;
  assign out_data   = out_valid ? head[OUT_WIDTH-1:0] : '0;

`ifdef WIDTH_GEARBOX_LAST_EN
  assign out_lanes = out_valid ? head[OUT_WIDTH +: LW] : '0;
  assign out_last  = out_valid & head[EW-1];
`else
  assign out_lanes = out_valid ? LW'((OUT_WIDTH > IN_WIDTH) ? R : 1) : '0;
  assign out_last  = 1'b0;
`endif

endmodule
